// File: rtl/matrix_result_collector_if.sv
// rtl/matrix_result_collector_if.sv - result handshake and drain stream bundle for matrix_result_collector
//
// Purpose: groups the multiplier-facing result handshake (z_*) and the
// row-major drain stream (out_*) into one bundle.
// Signals:
//   z_in      W      result data from the multiplier
//   z_i, z_j  IDX_W  row / column of the result
//   z_stb     1      result strobe, held until acknowledged
//   z_ack     1      single-cycle acknowledge from the collector
//   out_data  W      C[out_row][out_col]
//   out_row   IDX_W  row of the current drain beat
//   out_col   IDX_W  column of the current drain beat
//   out_valid 1      drain beat valid
//   out_ready 1      consumer ready
//   out_last  1      final beat (M-1, M-1)
// Modports: slave = collector side, master = multiplier + consumer side.

interface matrix_result_collector_if #(
  parameter int W     = 32,
  parameter int IDX_W = 2
);
  logic [W-1:0]     z_in;
  logic [IDX_W-1:0] z_i;
  logic [IDX_W-1:0] z_j;
  logic             z_stb;
  logic             z_ack;
  logic [W-1:0]     out_data;
  logic [IDX_W-1:0] out_row;
  logic [IDX_W-1:0] out_col;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  z_in, z_i, z_j, z_stb, out_ready,
    output z_ack, out_data, out_row, out_col, out_valid, out_last
  );

  modport master (
    output z_in, z_i, z_j, z_stb, out_ready,
    input  z_ack, out_data, out_row, out_col, out_valid, out_last
  );
endinterface

// File: rtl/matrix_result_collector.sv
// rtl/matrix_result_collector.sv - collects index-addressed multiplier results into C and drains C row-major
//
// Purpose: acknowledges each result beat from the multiplier, writes it into
// an M x M register matrix (later writes to the same cell overwrite), and on
// mm_done streams the matrix out row-major over a valid/ready stream.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   arms a new collection (IDLE only), clears C/count/err
//   mm_done      in   multiplier done pulse (COLLECT only)
//   bus          slave modport of matrix_result_collector_if (z_* and out_*)
//   busy         out  high in COLLECT or DRAIN
//   write_count  out  accepted writes since start, saturating
//   err          out  sticky protocol error, cleared by start

module matrix_result_collector #(
  parameter int M     = 4,
  parameter int W     = 32,
  parameter int IDX_W = (M > 1) ? $clog2(M) : 1,
  parameter int CNT_W = $clog2(M * M * M + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mm_done,
  matrix_result_collector_if.slave   bus,
  output logic                       busy,
  output logic [CNT_W-1:0]           write_count,
  output logic                       err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  // One extra bit so M itself is representable for the range compare.
  localparam logic [IDX_W:0]   M_L     = (IDX_W + 1)'(M);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(M - 1);

  state_t           state_q;
  logic [W-1:0]     c_q [M][M];
  logic             armed_q;
  logic             z_ack_q;
  logic             err_q;
  logic [CNT_W-1:0] wcnt_q;
  logic [IDX_W-1:0] row_q;
  logic [IDX_W-1:0] col_q;

  logic accept;
  logic in_range;
  logic at_last;

  // armed_q blocks a strobe that is still high after its ack from being
  // taken twice; it only re-arms once the strobe is seen low.
  assign accept   = (state_q == S_COLLECT) && bus.z_stb && !z_ack_q && armed_q;
  assign in_range = ({1'b0, bus.z_i} < M_L) && ({1'b0, bus.z_j} < M_L);
  assign at_last  = (row_q == MAX_IDX) && (col_q == MAX_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      z_ack_q <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < M; c++)
          c_q[r][c] <= '0;
    end else begin
      z_ack_q <= 1'b0;
      if (!bus.z_stb) armed_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.z_stb) err_q <= 1'b1;
          // start wins over a stray strobe in the same cycle.
          if (start) begin
            for (int r = 0; r < M; r++)
              for (int c = 0; c < M; c++)
                c_q[r][c] <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (accept) begin
            // Out-of-range beats are still acked and counted so the
            // multiplier never stalls, but they only flag err.
            if (in_range) c_q[bus.z_i][bus.z_j] <= bus.z_in;
            else          err_q <= 1'b1;
            if (wcnt_q != '1) wcnt_q <= wcnt_q + 1'b1;
            z_ack_q <= 1'b1;
            armed_q <= 1'b0;
          end
          if (mm_done) begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (bus.z_stb) err_q <= 1'b1;
          if (bus.out_ready) begin
            if (col_q == MAX_IDX) begin
              col_q <= '0;
              if (row_q == MAX_IDX) begin
                row_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.z_ack     = z_ack_q;
  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_data  = c_q[row_q][col_q];
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = (state_q == S_DRAIN) && at_last;
  assign busy          = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign write_count   = wcnt_q;
  assign err           = err_q;

endmodule

// File: tb/tb_matrix_result_collector.sv
// tb/tb_matrix_result_collector.sv - scoreboard testbench for matrix_result_collector

module tb_matrix_result_collector;
  localparam int M     = 4;
  localparam int W     = 32;
  localparam int IDX_W = 2;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             mm_done = 1'b0;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] write_count;

  matrix_result_collector_if #(.W(W), .IDX_W(IDX_W)) bus ();

  matrix_result_collector #(.M(M), .W(W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mm_done     (mm_done),
    .bus         (bus),
    .busy        (busy),
    .write_count (write_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] model_c [M][M];
  int          model_wc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer and checks that a stalled
  // beat does not change before it is taken.
  initial begin : monitor
    beat_t prev;
    beat_t cur;
    beat_t e;
    bit    stalled;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst || !bus.out_valid) begin
        stalled = 1'b0;
      end else begin
        cur.data = bus.out_data;
        cur.row  = bus.out_row;
        cur.col  = bus.out_col;
        cur.last = bus.out_last;
        if (stalled) begin
          check("hold_data", cur.data, prev.data);
          check("hold_coord", {27'd0, cur.row, cur.col, cur.last}, {27'd0, prev.row, prev.col, prev.last});
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", cur.data, e.data);
            check("beat_coord", {28'd0, cur.row, cur.col}, {28'd0, e.row, e.col});
            check("beat_last", {31'd0, cur.last}, {31'd0, e.last});
          end
        end
        stalled = !bus.out_ready;
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++)
        model_c[r][c] = 32'd0;
    model_wc = 0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_z_ack"}, {31'd0, bus.z_ack}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_last"}, {31'd0, bus.out_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_write_count"}, {25'd0, write_count}, 32'd0);
    check({tag, "_out_data"}, bus.out_data, 32'd0);
  endtask

  // Multiplier-style handshake: strobe held through the ack cycle, dropped after.
  task automatic handshake(input int i, input int j, input logic [31:0] d, input bit chk_timing);
    int n;
    bus.z_i   = 2'(i);
    bus.z_j   = 2'(j);
    bus.z_in  = d;
    bus.z_stb = 1'b1;
    n = 0;
    tick();
    while (!bus.z_ack && n < 8) begin
      tick();
      n++;
    end
    check("ack_seen", {31'd0, bus.z_ack}, 32'd1);
    if (chk_timing) check("ack_latency", n, 32'd0);
    tick();
    if (chk_timing) check("ack_width", {31'd0, bus.z_ack}, 32'd0);
    bus.z_stb = 1'b0;
    tick();
    model_c[i][j] = d;
    if (model_wc < 127) model_wc++;
  endtask

  task automatic push_expected;
    beat_t e;
    for (int d = 0; d < M * M; d++) begin
      e.data = model_c[d / M][d % M];
      e.row  = 2'(d / M);
      e.col  = 2'(d % M);
      e.last = (d == M * M - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input bit toggle);
    int cnt;
    push_expected();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    check("drain_entry_valid", {31'd0, bus.out_valid}, 32'd1);
    cnt = 0;
    while (busy && cnt < 100) begin
      bus.out_ready = toggle ? (cnt % 2 == 0) : 1'b1;
      tick();
      cnt++;
    end
    bus.out_ready = 1'b0;
    check("drain_cycles", cnt, toggle ? 32'd31 : 32'd16);
    check("drain_busy_clear", {31'd0, busy}, 32'd0);
    check("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin : stimulus
    int acks;
    bus.z_in      = '0;
    bus.z_i       = '0;
    bus.z_j       = '0;
    bus.z_stb     = 1'b0;
    bus.out_ready = 1'b0;
    clear_model();

    // Reset values.
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("por");

    // Asynchronous reset mid-cycle with random inputs after a write.
    pulse_start();
    handshake(0, 0, 32'hDEADBEEF, 1'b0);
    bus.z_stb     = 1'($urandom_range(0, 1));
    bus.z_in      = $urandom;
    bus.z_i       = 2'($urandom_range(0, 3));
    bus.z_j       = 2'($urandom_range(0, 3));
    bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bus.z_stb     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // mm_done in IDLE is ignored.
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    check("idle_mm_done_busy", {31'd0, busy}, 32'd0);

    // Single handshake.
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    handshake(1, 2, 32'h3F800000, 1'b1);
    check("single_wc", {25'd0, write_count}, 32'd1);
    drain(1'b0);

    // Held strobe: one ack over six cycles, then a second handshake.
    pulse_start();
    bus.z_i   = 2'd2;
    bus.z_j   = 2'd3;
    bus.z_in  = 32'h11223344;
    bus.z_stb = 1'b1;
    acks = 0;
    repeat (6) begin
      tick();
      acks += int'(bus.z_ack);
    end
    bus.z_stb = 1'b0;
    tick();
    check("held_ack_count", acks, 32'd1);
    check("held_wc", {25'd0, write_count}, 32'd1);
    model_c[2][3] = 32'h11223344;
    model_wc = 1;
    handshake(3, 1, 32'h55667788, 1'b0);
    check("held_wc2", {25'd0, write_count}, 32'd2);
    drain(1'b0);

    // Overwrite of the same cell; final value must win.
    pulse_start();
    handshake(0, 0, 32'h3F800000, 1'b0);
    handshake(0, 0, 32'h40000000, 1'b0);
    handshake(0, 0, 32'h40400000, 1'b0);
    check("overwrite_wc", {25'd0, write_count}, 32'd3);
    drain(1'b0);

    // Full run: 64 partial sums, drain with ready toggling.
    pulse_start();
    for (int k = 0; k < M; k++)
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++)
          handshake(i, j, 32'h40000000 | 32'(k << 8) | 32'(i << 4) | 32'(j), 1'b0);
    check("full_wc", {25'd0, write_count}, 32'd64);
    drain(1'b1);
    check("full_err", {31'd0, err}, 32'd0);

    // Strobe during DRAIN, then reset at beat 5.
    pulse_start();
    handshake(2, 2, 32'hCAFEF00D, 1'b0);
    push_expected();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    bus.z_stb = 1'b1;
    repeat (2) begin
      tick();
      check("drain_no_ack", {31'd0, bus.z_ack}, 32'd0);
    end
    bus.z_stb = 1'b0;
    check("drain_strobe_err", {31'd0, err}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("mid_drain_rst");
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Strobe in IDLE flags err; start clears it.
    bus.z_stb = 1'b1;
    tick();
    bus.z_stb = 1'b0;
    check("idle_strobe_err", {31'd0, err}, 32'd1);
    tick();
    pulse_start();
    check("start_clears_err", {31'd0, err}, 32'd0);
    check("start_clears_wc", {25'd0, write_count}, 32'd0);
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matrix_result_collector.md
# matrix_result_collector

Responder end of the multiplier's result handshake (z_out/z_i/z_j/z_stb/z_ack). It acknowledges every result beat and writes it into an M×M register-array result matrix C. Later partial sums for the same (i,j) overwrite earlier ones. When the multiplier signals completion, the block streams C out row-major over a valid/ready interface. It sits beside sequential_matrix_multiplier and decouples the result consumer from the multiplier's index-addressed protocol.

## Interface
- M, default 4: matrix dimension; C holds M*M words.
- W, default 32: data width (IEEE-754 single, opaque to this block).
- IDX_W, default max(1, clog2(M)): index width, matching the multiplier's z_i/z_j.
- CNT_W, default clog2(M*M*M+1): write counter width.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse from the same source as the multiplier's start; arms collection.
- z_in  in  W  result data (multiplier z_out).
- z_i, z_j  in  IDX_W  row and column of the result.
- z_stb  in  1  result strobe; held high until acknowledged.
- z_ack  out  1  single-cycle acknowledge.
- mm_done  in  1  multiplier done pulse.
- out_data  out  W  C[out_row][out_col].
- out_row, out_col  out  IDX_W  coordinates of the current beat.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  consumer ready.
- out_last  out  1  high with the final beat (M-1, M-1).
- busy  out  1  high in COLLECT or DRAIN.
- write_count  out  CNT_W  accepted writes since start; saturating.
- err  out  1  sticky protocol error; cleared by start.

## Operation
- States:
  - IDLE: wait for start. On start: clear all C entries to 0, write_count to 0 and err to 0, re-arm, go to COLLECT.
  - COLLECT: accept results. On mm_done, go to DRAIN.
  - DRAIN: stream C row-major. After the out_last transfer, go to IDLE.
  - Illegal state encoding: go to IDLE.
- Accept rule, all of:
  - state is COLLECT;
  - z_stb=1;
  - z_ack=0;
  - the block is armed.
- Effect of an accept:
  - C[z_i][z_j] <= z_in;
  - write_count increments, saturating at all-ones;
  - z_ack <= 1 for exactly one cycle;
  - armed <= 0.
- Re-arm: armed <= 1 on any cycle z_stb is sampled low. A strobe held high across the ack therefore produces exactly one write.
- Out-of-range index: if z_i ≥ M or z_j ≥ M (non-power-of-2 M), no write occurs, but the beat is still acked, counted and sets err.
- z_stb sampled high while in IDLE or DRAIN: no ack, no write, err <= 1.
- mm_done in the same cycle as an accept: the write completes, then the state moves to DRAIN.
- mm_done in IDLE or DRAIN is ignored.
- start in COLLECT or DRAIN is ignored.
- Drain sequencing:
  - A flat index d runs 0..M*M-1, with out_row = d / M and out_col = d % M. Use separate row/col counters, no divider.
  - out_valid = (state==DRAIN).
  - out_data, out_row, out_col and out_last are combinational from the counters and C.
  - d advances on out_valid && out_ready.
  - All outputs hold stable while out_ready=0.

## Timing
- Reset values:
  - state IDLE;
  - z_ack, out_valid, out_last, busy, err: 0;
  - write_count: 0;
  - row/col counters: 0, so out_row = out_col = 0 and out_data = C[0][0] = 0;
  - all C entries: 0;
  - armed: 1.
- Reset mid-operation aborts any collection or drain immediately; no partial beats follow.
- Ack latency: z_ack rises the cycle after z_stb is first sampled high and lasts 1 cycle.
- With the multiplier's response (z_stb drops the cycle after z_ack), one handshake occupies 3 cycles.
- C entry written at the accept edge is visible on out_data from the next cycle.
- COLLECT→DRAIN: out_valid is high in the first cycle after the edge that samples mm_done.
- Drain throughput: 1 beat/cycle. With out_ready held high, the drain takes exactly M*M cycles, then busy=0 on the following cycle.
- start→busy: busy is high the cycle after start is sampled.

## Test plan
- Reset: assert rst=0 mid-cycle with random inputs. Required, asynchronously: z_ack=0, out_valid=0, busy=0, err=0, write_count=0, out_data=0.
- Single handshake: start, then z_stb=1, z_i=1, z_j=2, z_in=0x3F800000, held until ack. Required:
  - z_ack high exactly 1 cycle, one cycle after the first sample;
  - write_count=1;
  - after mm_done, beat 6 shows 0x3F800000 at (1,2);
  - all other beats show 0.
- Held strobe: z_stb held high for 6 cycles with one address. Required: exactly one z_ack pulse and write_count=1. After a low cycle and a new strobe, write_count=2.
- Overwrite: three handshakes to (0,0) with 0x3F800000, 0x40000000, 0x40400000. Required: drain beat 0 = 0x40400000.
- Full M=4 run: 64 handshakes, then mm_done, with out_ready toggling 1,0,1,0. Required:
  - write_count=64;
  - 16 beats row-major with data unchanged while ready=0;
  - out_last only on (3,3);
  - err=0.
- Protocol errors and reset mid-drain: z_stb during DRAIN gives no ack and sets err=1. rst=0 at beat 5 leaves all outputs at reset values. A subsequent start clears err and C.
